z80_mem_bridge: RTL and testbench
=================================

Z80_MEM_BRIDGE -- requirements
Module: z80_mem_bridge

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000: base of the 1 KiB RAM window; bits [9:0] shall be zero.
REQ-002 Parameter UNMAPPED_DATA, default 8'hFF: value returned on reads outside the window.
REQ-003 clk  in  1  single clock, shared with CPU core and RAM; all state changes on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cpu_addr  in  16  CPU address bus.
REQ-006 cpu_dout  in  8  CPU write data.
REQ-007 mreq_n, rd_n, wr_n  in  1 each  CPU memory-request, read and write strobes, active-low.
REQ-008 cpu_din  out  8  read data to CPU, registered.
REQ-009 wait_n  out  1  CPU wait request, active-low.
REQ-010 hit  out  1  combinational; 1 when mreq_n=0 and cpu_addr[15:10]==BASE_ADDR[15:10].
REQ-011 mem_addr  out  10  RAM address, registered.
REQ-012 mem_wdata  out  8  RAM write data, registered.
REQ-013 mem_we  out  1  RAM write enable, registered.
REQ-014 mem_rdata  in  8  RAM read data, valid one clk after mem_addr is presented.

Function
REQ-015 FSM states: IDLE, RD_ADDR, RD_LATCH, RD_DONE, WR_DONE.
REQ-016 Read request = hit & ~rd_n & wr_n; write request = hit & ~wr_n & rd_n.
REQ-017 IDLE plus read request: mem_addr <= cpu_addr[9:0]; next state RD_ADDR.
REQ-018 RD_ADDR: next state RD_LATCH, with no other action.
REQ-019 RD_LATCH: cpu_din <= mem_rdata; next state RD_DONE.
REQ-020 wait_n shall be combinational: 0 in IDLE-with-read-request, RD_ADDR and RD_LATCH; 1 otherwise.
REQ-021 Read latency: request seen in cycle N gives cpu_din valid and wait_n=1 in cycle N+3.
REQ-022 RD_DONE shall hold cpu_din until mreq_n=1 or rd_n=1, then go to IDLE.
REQ-023 IDLE plus write request: mem_addr <= cpu_addr[9:0], mem_wdata <= cpu_dout, mem_we <= 1; next state WR_DONE.
REQ-024 mem_we shall be high for exactly one clk per CPU write cycle.
REQ-025 Writes shall never assert wait_n=0.
REQ-026 WR_DONE shall go to IDLE when mreq_n=1 or wr_n=1; a held strobe shall never re-issue mem_we.
REQ-027 Unmapped read (mreq_n=0, rd_n=0, hit=0): cpu_din <= UNMAPPED_DATA, no wait, no RAM access.
REQ-028 Unmapped write: ignored; mem_we stays 0.
REQ-029 rd_n=0 and wr_n=0 together: no-op; FSM stays in IDLE and mem_we stays 0.
REQ-030 Abort (mreq_n or rd_n returns to 1 in RD_ADDR or RD_LATCH): go to IDLE at the next edge; cpu_din keeps its previous value.
REQ-031 Address wrap: cpu_addr[9:0]=10'h3FF maps to mem_addr 10'h3FF; the next window address maps to 10'h000.
REQ-032 Back-to-back cycles: a new request is accepted only from IDLE, at the earliest one clk after a strobe deassertion.

Reset
REQ-033 While reset=1: state=IDLE, mem_addr=0, mem_wdata=0, mem_we=0, cpu_din=UNMAPPED_DATA; wait_n=1 (follows from state).
REQ-034 After reset, a flag "armed" shall be 0 and set only when mreq_n=1 is sampled; requests while armed=0 are ignored.
REQ-035 Reset mid-read or mid-write shall drop mem_we immediately; no partial write is issued after release.

Structure
REQ-036 Package z80_bus_pkg shall hold the FSM state enum, MEM_AW=10 and the default UNMAPPED_DATA.
REQ-037 Decode and FSM shall be a single module with no sub-module; the testbench supplies a RAM model with one-cycle read latency.

Verification
REQ-038 Read hit: RAM[0x123]=0x5A, cpu_addr=0x0123, mreq_n=rd_n=0 -> wait_n=0 for 3 clks, then cpu_din=0x5A with wait_n=1.
REQ-039 Write hit: cpu_addr=0x03FF, cpu_dout=0xC3, wr_n held low 4 clks -> exactly one mem_we pulse with mem_addr=0x3FF and mem_wdata=0xC3; readback gives 0xC3.
REQ-040 Unmapped: cpu_addr=0x0400 read -> cpu_din=0xFF with no wait; write 0x77 -> mem_we never asserted.
REQ-041 Abort: rd_n released in RD_ADDR -> IDLE next clk; cpu_din unchanged; wait_n=1.
REQ-042 Reset during RD_LATCH with strobes held low -> wait_n=1 and cpu_din=0xFF; no access until mreq_n goes high and a new cycle starts.
REQ-043 Illegal rd_n=wr_n=0 with hit -> no mem_we and state stays IDLE; a following normal write to 0x0010 succeeds.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 memory bridge: FSM states, RAM
// address width and the default value driven for unmapped reads.
package z80_bus_pkg;

   localparam int MEM_AW = 10;
   localparam logic [7:0] UNMAPPED_DATA_DEF = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_LATCH,
      ST_RD_DONE,
      ST_WR_DONE
   } bus_state_e;

endpackage

// File: rtl/z80_mem_bridge.sv
// Bridges Z80 memory cycles onto a 1 KiB synchronous RAM with one-cycle read
// latency; reads stall the CPU through wait_n, writes complete without wait.
module z80_mem_bridge
   import z80_bus_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR     = 16'h0000,
   parameter logic [7:0]  UNMAPPED_DATA = UNMAPPED_DATA_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       cpu_addr,
   input  logic [7:0]        cpu_dout,
   input  logic              mreq_n,
   input  logic              rd_n,
   input  logic              wr_n,
   output logic [7:0]        cpu_din,
   output logic              wait_n,
   output logic              hit,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic [7:0]        mem_rdata
);

   bus_state_e        state_q, state_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d;
   logic [7:0]        cpu_din_q, cpu_din_d;
   logic              armed_q, armed_d;
   logic              rd_req, wr_req, unmapped_rd;

   always_comb begin
      hit         = ~mreq_n && (cpu_addr[15:10] == BASE_ADDR[15:10]);
      // Nothing is accepted after reset until the CPU has shown an idle bus.
      rd_req      = armed_q & hit & ~rd_n & wr_n;
      wr_req      = armed_q & hit & ~wr_n & rd_n;
      unmapped_rd = armed_q & ~mreq_n & ~hit & ~rd_n & wr_n;
   end

   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      cpu_din_d   = cpu_din_q;
      armed_d     = armed_q | mreq_n;
      wait_n      = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (rd_req) begin
               mem_addr_d = cpu_addr[MEM_AW-1:0];
               wait_n     = 1'b0;
               state_d    = ST_RD_ADDR;
            end else if (wr_req) begin
               mem_addr_d  = cpu_addr[MEM_AW-1:0];
               mem_wdata_d = cpu_dout;
               mem_we_d    = 1'b1;
               state_d     = ST_WR_DONE;
            end else if (unmapped_rd) begin
               cpu_din_d = UNMAPPED_DATA;
            end
         end
         ST_RD_ADDR: begin
            wait_n  = 1'b0;
            state_d = (mreq_n | rd_n) ? ST_IDLE : ST_RD_LATCH;
         end
         ST_RD_LATCH: begin
            wait_n = 1'b0;
            if (mreq_n | rd_n) begin
               state_d = ST_IDLE;
            end else begin
               cpu_din_d = mem_rdata;
               state_d   = ST_RD_DONE;
            end
         end
         ST_RD_DONE: begin
            if (mreq_n | rd_n) state_d = ST_IDLE;
         end
         ST_WR_DONE: begin
            // Held strobe parks here so mem_we cannot re-fire.
            if (mreq_n | wr_n) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         cpu_din_q   <= UNMAPPED_DATA;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         cpu_din_q   <= cpu_din_d;
         armed_q     <= armed_d;
      end
   end

   assign cpu_din   = cpu_din_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_z80_mem_bridge.sv
// Bench for z80_mem_bridge: directed corner cases plus random bus cycles,
// checked against a transaction-level memory image kept by the bench.
module tb_z80_mem_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_dout = '0;
   logic        mreq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
   logic [7:0]  cpu_din;
   logic        wait_n, hit;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata = '0;

   z80_mem_bridge dut (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
      .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n), .cpu_din(cpu_din),
      .wait_n(wait_n), .hit(hit), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // RAM with one-cycle read latency
   logic [7:0] ram [1024];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   int         we_cnt = 0;
   logic [9:0] we_addr = '0;
   logic [7:0] we_data = '0;
   always @(negedge clk) begin
      if (mem_we) begin
         we_cnt  <= we_cnt + 1;
         we_addr <= mem_addr;
         we_data <= mem_wdata;
      end
   end

   logic [7:0] ref_mem [1024];
   logic [7:0] last_din = 8'hFF;
   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [15:0] a, input int hold);
      bit         mapped;
      logic [7:0] exp_d;
      int         waits;
      mapped = (a < 16'h0400);
      exp_d  = mapped ? ref_mem[a[9:0]] : 8'hFF;
      waits  = 0;
      cpu_addr = a; mreq_n = 0; rd_n = 0; wr_n = 1;
      #3;
      chk("rd_hit", hit, mapped);
      if (mapped) begin
         while (wait_n == 1'b0 && waits < 8) begin
            waits++;
            cyc(); #3;
         end
         chk("rd_waits", waits, 3);
      end else begin
         chk("ur_nowait", wait_n, 1);
         cyc(); #3;
      end
      chk("rd_data", cpu_din, exp_d);
      last_din = exp_d;
      for (int i = 0; i < hold; i++) begin
         cyc(); #3;
         chk("rd_hold", cpu_din, exp_d);
         chk("rd_hold_wait", wait_n, 1);
      end
      cyc();
      mreq_n = 1; rd_n = 1;
      cyc();
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int hold);
      bit mapped;
      int c0;
      mapped = (a < 16'h0400);
      c0 = we_cnt;
      cpu_addr = a; cpu_dout = d; mreq_n = 0; wr_n = 0; rd_n = 1;
      #3;
      chk("wr_hit", hit, mapped);
      chk("wr_nowait", wait_n, 1);
      for (int i = 0; i <= hold; i++) begin
         cyc(); #3;
         chk("wr_nowait_h", wait_n, 1);
      end
      cyc();
      mreq_n = 1; wr_n = 1;
      cyc();
      chk("wr_pulses", we_cnt - c0, mapped ? 1 : 0);
      if (mapped) begin
         chk("wr_addr", we_addr, a[9:0]);
         chk("wr_data", we_data, d);
         ref_mem[a[9:0]] = d;
      end
   endtask

   initial begin
      int c0;
      for (int i = 0; i < 1024; i++) begin
         logic [7:0] v;
         v = 8'($urandom);
         ram[i] <= v;
         ref_mem[i] = v;
      end
      ram[10'h123] <= 8'h5A;
      ref_mem[10'h123] = 8'h5A;

      // Reset state
      repeat (2) @(posedge clk);
      #3;
      chk("rst_din", cpu_din, 8'hFF);
      chk("rst_wait", wait_n, 1);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_hit", hit, 0);
      cyc();
      reset = 0;
      cyc();

      // Basic read, write at top of window, readback, wrap to address 0
      do_read(16'h0123, 1);
      do_write(16'h03FF, 8'hC3, 3);
      do_read(16'h03FF, 0);
      do_write(16'h0000, 8'h3C, 0);
      do_read(16'h0000, 0);
      do_read(16'h03FF, 0);

      // Unmapped read and write
      do_read(16'h0400, 0);
      do_write(16'h0400, 8'h77, 2);
      do_read(16'h0123, 0);

      // Abort in RD_ADDR
      cpu_addr = 16'h0200; mreq_n = 0; rd_n = 0;
      cyc();
      rd_n = 1;
      #3 chk("abort_a_wait_in", wait_n, 0);
      cyc(); #3;
      chk("abort_a_wait", wait_n, 1);
      chk("abort_a_din", cpu_din, last_din);
      cyc();
      mreq_n = 1;
      cyc();

      // Abort in RD_LATCH
      cpu_addr = 16'h0201; mreq_n = 0; rd_n = 0;
      cyc(); cyc();
      mreq_n = 1;
      cyc(); #3;
      chk("abort_l_wait", wait_n, 1);
      chk("abort_l_din", cpu_din, last_din);
      rd_n = 1;
      cyc();

      // Both strobes low with a hit: no-op
      c0 = we_cnt;
      cpu_addr = 16'h0010; cpu_dout = 8'h99; mreq_n = 0; rd_n = 0; wr_n = 0;
      for (int i = 0; i < 3; i++) begin
         #3 chk("ill_wait", wait_n, 1);
         cyc();
      end
      mreq_n = 1; rd_n = 1; wr_n = 1;
      cyc();
      chk("ill_pulses", we_cnt - c0, 0);
      do_write(16'h0010, 8'h5C, 0);
      do_read(16'h0010, 0);

      // Reset during RD_LATCH with strobes held low
      c0 = we_cnt;
      cpu_addr = 16'h0123; mreq_n = 0; rd_n = 0;
      cyc(); cyc();
      reset = 1;
      #1;
      chk("rrst_wait", wait_n, 1);
      chk("rrst_din", cpu_din, 8'hFF);
      cyc();
      reset = 0;
      last_din = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         cyc(); #3;
         chk("rrst_idle_wait", wait_n, 1);
         chk("rrst_idle_din", cpu_din, 8'hFF);
      end
      cyc();
      mreq_n = 1; rd_n = 1;
      cyc();
      do_read(16'h0123, 0);

      // Reset while mem_we is high, strobe still held after release
      c0 = we_cnt;
      cpu_addr = 16'h0050; cpu_dout = ~ref_mem[10'h050]; mreq_n = 0; wr_n = 0;
      cyc();
      reset = 1;
      #1 chk("wrst_we", mem_we, 0);
      cyc();
      reset = 0;
      repeat (3) cyc();
      chk("wrst_pulses", we_cnt - c0, 0);
      mreq_n = 1; wr_n = 1;
      cyc();
      do_read(16'h0050, 0);

      // Random bus cycles
      for (int n = 0; n < 200; n++) begin
         logic [15:0] a;
         a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023));
         if ($urandom_range(0, 1) == 0) do_read(a, $urandom_range(0, 3));
         else do_write(a, 8'($urandom), $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
